// File: rtl/pipeline_hazard_responder.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_responder
//
// Purpose: applies the hazard unit's stall/flush/bypass decisions to a
// five-stage pipeline. It drives the PC/IF-ID write enable, holds the IF/ID,
// ID/EX and EX/MEM pipeline registers, resolves the execute operands through
// the MEM/WB bypass muxes, and watches for runaway stalls.
//
// Optional feature: define HAZARD_PERF_CNT_EN to build the two 32-bit
// performance counters. Without it both counter ports are tied to 0.
//
// Parameters:
//   STALL_LIMIT         consecutive stall cycles that trip w_stall_err
//
// Ports:
//   clock, reset                 clock and synchronous active-high reset
//   w_stall, w_flush             stall / flush requests
//   w_me_rs/rt_bypass            decode operand takes MEM ALU result
//   w_we_rs/rt_bypass            decode operand takes WB data
//   w_wm_rt_bypass               store data replaced by WB data at EX/MEM
//   w_instr_32                   fetched instruction
//   w_drs/drt_data_32            register-file read data in decode
//   w_malu_result_32             ALU result in MEM
//   w_wb_data_32                 write-back data
//   w_pc_en                      PC and IF/ID write enable
//   w_fd_valid, w_fd_instr_32    IF/ID register
//   w_de_valid                   ID/EX valid (0 = bubble)
//   w_ers/ert_data_32            resolved execute operands
//   w_em_valid, w_em_rt_data_32  EX/MEM register
//   w_stall_err                  sticky watchdog error
//   w_stall_cycles_32            cycles with w_stall asserted
//   w_bypass_events_32           ID/EX loads carrying any bypass select
// ---------------------------------------------------------------------------
module pipeline_hazard_responder #(
    parameter int STALL_LIMIT = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        w_stall,
    input  logic        w_flush,
    input  logic        w_me_rs_bypass,
    input  logic        w_me_rt_bypass,
    input  logic        w_we_rs_bypass,
    input  logic        w_we_rt_bypass,
    input  logic        w_wm_rt_bypass,
    input  logic [31:0] w_instr_32,
    input  logic [31:0] w_drs_data_32,
    input  logic [31:0] w_drt_data_32,
    input  logic [31:0] w_malu_result_32,
    input  logic [31:0] w_wb_data_32,
    output logic        w_pc_en,
    output logic        w_fd_valid,
    output logic [31:0] w_fd_instr_32,
    output logic        w_de_valid,
    output logic [31:0] w_ers_data_32,
    output logic [31:0] w_ert_data_32,
    output logic        w_em_valid,
    output logic [31:0] w_em_rt_data_32,
    output logic        w_stall_err,
    output logic [31:0] w_stall_cycles_32,
    output logic [31:0] w_bypass_events_32
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        FLUSH = 2'd3
    } state_t;

    localparam int               CNT_W = $clog2(STALL_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STALL_LIMIT);

    state_t state_q;
    state_t state_d;

    // ID/EX latched operands and bypass selects
    logic [31:0] rs_data_p1;
    logic [31:0] rt_data_p1;
    logic        sel_me_rs_p1;
    logic        sel_me_rt_p1;
    logic        sel_we_rs_p1;
    logic        sel_we_rt_p1;

    logic [CNT_W-1:0] stall_cnt;
    logic             issue;
    logic             any_sel;

    // An instruction issues into ID/EX only when neither a stall nor a flush
    // forces a bubble; the selects it captures are used for that one cycle.
    assign issue   = !(w_flush || w_stall);
    assign any_sel = w_me_rs_bypass | w_me_rt_bypass | w_we_rs_bypass | w_we_rt_bypass;

    // A flush always redirects the PC, even when a stall is raised alongside.
    assign w_pc_en = (state_q != IDLE) && (!w_stall || w_flush);

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       state_d = RUN;
            RUN, STALL: state_d = w_flush ? FLUSH : (w_stall ? STALL : RUN);
            FLUSH:      state_d = w_stall ? STALL : RUN;
            default:    state_d = IDLE;
        endcase
    end

    // ---- IF/ID ----
    always_ff @(posedge clock) begin
        if (reset) begin
            w_fd_valid    <= 1'b0;
            w_fd_instr_32 <= 32'd0;
        end else if (w_flush) begin
            w_fd_valid    <= 1'b0;
        end else if (w_pc_en) begin
            w_fd_valid    <= (state_q != IDLE);
            w_fd_instr_32 <= w_instr_32;
        end
    end

    // ---- ID/EX ----
    always_ff @(posedge clock) begin
        if (reset) begin
            w_de_valid   <= 1'b0;
            rs_data_p1   <= 32'd0;
            rt_data_p1   <= 32'd0;
            sel_me_rs_p1 <= 1'b0;
            sel_me_rt_p1 <= 1'b0;
            sel_we_rs_p1 <= 1'b0;
            sel_we_rt_p1 <= 1'b0;
        end else if (!issue) begin
            // Bubble: operands are held, only valid and selects are cleared.
            w_de_valid   <= 1'b0;
            sel_me_rs_p1 <= 1'b0;
            sel_me_rt_p1 <= 1'b0;
            sel_we_rs_p1 <= 1'b0;
            sel_we_rt_p1 <= 1'b0;
        end else begin
            w_de_valid   <= w_fd_valid;
            rs_data_p1   <= w_drs_data_32;
            rt_data_p1   <= w_drt_data_32;
            sel_me_rs_p1 <= w_me_rs_bypass;
            sel_me_rt_p1 <= w_me_rt_bypass;
            sel_we_rs_p1 <= w_we_rs_bypass;
            sel_we_rt_p1 <= w_we_rt_bypass;
        end
    end

    // MEM result is younger than WB data, so it wins when both are selected.
    assign w_ers_data_32 = sel_me_rs_p1 ? w_malu_result_32 :
                           sel_we_rs_p1 ? w_wb_data_32     : rs_data_p1;
    assign w_ert_data_32 = sel_me_rt_p1 ? w_malu_result_32 :
                           sel_we_rt_p1 ? w_wb_data_32     : rt_data_p1;

    // ---- EX/MEM ----
    always_ff @(posedge clock) begin
        if (reset) begin
            w_em_valid      <= 1'b0;
            w_em_rt_data_32 <= 32'd0;
        end else begin
            w_em_valid      <= w_de_valid & ~w_flush;
            w_em_rt_data_32 <= w_wm_rt_bypass ? w_wb_data_32 : w_ert_data_32;
        end
    end

    // ---- stall watchdog ----
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt   <= '0;
            w_stall_err <= 1'b0;
        end else if (w_stall) begin
            if (stall_cnt != LIMIT) stall_cnt <= stall_cnt + 1'b1;
            // Fires on the edge at which the counter reaches the limit.
            if (stall_cnt >= LIMIT - 1'b1) w_stall_err <= 1'b1;
        end else begin
            stall_cnt <= '0;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            w_stall_cycles_32  <= 32'd0;
            w_bypass_events_32 <= 32'd0;
        end else begin
            if (w_stall)           w_stall_cycles_32  <= w_stall_cycles_32 + 32'd1;
            if (issue && any_sel)  w_bypass_events_32 <= w_bypass_events_32 + 32'd1;
        end
    end
`else
    assign w_stall_cycles_32  = 32'd0;
    assign w_bypass_events_32 = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_responder.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_responder
//
// Directed bench: reset/startup sequence, a table of per-cycle vectors with
// hand-computed register contents, a stall watchdog sequence and a reset
// applied during a simultaneous stall and flush.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic        w_stall, w_flush;
    logic        w_me_rs_bypass, w_me_rt_bypass, w_we_rs_bypass, w_we_rt_bypass;
    logic        w_wm_rt_bypass;
    logic [31:0] w_instr_32, w_drs_data_32, w_drt_data_32;
    logic [31:0] w_malu_result_32, w_wb_data_32;
    logic        w_pc_en, w_fd_valid, w_de_valid, w_em_valid, w_stall_err;
    logic [31:0] w_fd_instr_32, w_ers_data_32, w_ert_data_32, w_em_rt_data_32;
    logic [31:0] w_stall_cycles_32, w_bypass_events_32;

    int checks = 0;
    int errors = 0;
    int tb_stalls = 0;
    int tb_bypasses = 0;

    always #5 clock = ~clock;

    pipeline_hazard_responder #(.STALL_LIMIT(8)) dut (
        .clock              (clock),
        .reset              (reset),
        .w_stall            (w_stall),
        .w_flush            (w_flush),
        .w_me_rs_bypass     (w_me_rs_bypass),
        .w_me_rt_bypass     (w_me_rt_bypass),
        .w_we_rs_bypass     (w_we_rs_bypass),
        .w_we_rt_bypass     (w_we_rt_bypass),
        .w_wm_rt_bypass     (w_wm_rt_bypass),
        .w_instr_32         (w_instr_32),
        .w_drs_data_32      (w_drs_data_32),
        .w_drt_data_32      (w_drt_data_32),
        .w_malu_result_32   (w_malu_result_32),
        .w_wb_data_32       (w_wb_data_32),
        .w_pc_en            (w_pc_en),
        .w_fd_valid         (w_fd_valid),
        .w_fd_instr_32      (w_fd_instr_32),
        .w_de_valid         (w_de_valid),
        .w_ers_data_32      (w_ers_data_32),
        .w_ert_data_32      (w_ert_data_32),
        .w_em_valid         (w_em_valid),
        .w_em_rt_data_32    (w_em_rt_data_32),
        .w_stall_err        (w_stall_err),
        .w_stall_cycles_32  (w_stall_cycles_32),
        .w_bypass_events_32 (w_bypass_events_32)
    );

    typedef struct {
        logic        stall, flush, me_rs, me_rt, we_rs, we_rt, wm;
        logic [31:0] instr, drs, drt, malu, wb;
        logic        e_pc_en;      // before the edge
        logic [1:0]  e_state;      // after the edge
        logic        e_fd_valid;
        logic [31:0] e_fd_instr;
        logic        e_de_valid;
        logic [31:0] e_ers, e_ert;
        logic        e_em_valid;
        logic [31:0] e_em_rt;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        w_stall          = v.stall;
        w_flush          = v.flush;
        w_me_rs_bypass   = v.me_rs;
        w_me_rt_bypass   = v.me_rt;
        w_we_rs_bypass   = v.we_rs;
        w_we_rt_bypass   = v.we_rt;
        w_wm_rt_bypass   = v.wm;
        w_instr_32       = v.instr;
        w_drs_data_32    = v.drs;
        w_drt_data_32    = v.drt;
        w_malu_result_32 = v.malu;
        w_wb_data_32     = v.wb;
    endtask

    // Bookkeeping of what the bench drove, for the optional counters.
    task automatic count_edge();
        if (w_stall) tb_stalls++;
        if (!w_stall && !w_flush &&
            (w_me_rs_bypass || w_me_rt_bypass || w_we_rs_bypass || w_we_rt_bypass))
            tb_bypasses++;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " pc_en"},    32'(w_pc_en), 32'd0);
        chk({tag, " state"},    32'(dut.state_q), 32'd0);
        chk({tag, " fd_valid"}, 32'(w_fd_valid), 32'd0);
        chk({tag, " fd_instr"}, w_fd_instr_32, 32'd0);
        chk({tag, " de_valid"}, 32'(w_de_valid), 32'd0);
        chk({tag, " ers"},      w_ers_data_32, 32'd0);
        chk({tag, " ert"},      w_ert_data_32, 32'd0);
        chk({tag, " em_valid"}, 32'(w_em_valid), 32'd0);
        chk({tag, " em_rt"},    w_em_rt_data_32, 32'd0);
        chk({tag, " stall_err"},32'(w_stall_err), 32'd0);
        chk({tag, " stall_cycles"},  w_stall_cycles_32, 32'd0);
        chk({tag, " bypass_events"}, w_bypass_events_32, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t idle_v;
        logic [31:0] exp_sc, exp_be;

        //          st fl mrs mrt wrs wrt wm instr          drs    drt    malu   wb     pc st fdv fdi            dev ers    ert    emv emrt
        tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 32'h1000_0001, 32'h11, 32'h22, 32'hAA, 32'hBB, 1, 1, 1, 32'h1000_0001, 0, 32'h11, 32'h22, 0, 32'h00};
        tbl[1]  = '{0, 0, 1, 0, 0, 0, 0, 32'h1000_0002, 32'h11, 32'h22, 32'hAA, 32'hBB, 1, 1, 1, 32'h1000_0002, 1, 32'hAA, 32'h22, 0, 32'h22};
        tbl[2]  = '{0, 0, 0, 0, 1, 0, 0, 32'h1000_0003, 32'h11, 32'h22, 32'hAA, 32'hBB, 1, 1, 1, 32'h1000_0003, 1, 32'hBB, 32'h22, 1, 32'h22};
        tbl[3]  = '{0, 0, 1, 0, 1, 1, 0, 32'h1000_0004, 32'h11, 32'h22, 32'hAA, 32'hBB, 1, 1, 1, 32'h1000_0004, 1, 32'hAA, 32'hBB, 1, 32'h22};
        tbl[4]  = '{0, 0, 0, 0, 0, 0, 1, 32'h1000_0005, 32'h33, 32'h44, 32'hAA, 32'hBB, 1, 1, 1, 32'h1000_0005, 1, 32'h33, 32'h44, 1, 32'hBB};
        tbl[5]  = '{1, 0, 0, 0, 0, 0, 0, 32'h1000_0006, 32'h33, 32'h44, 32'hAA, 32'hBB, 0, 2, 1, 32'h1000_0005, 0, 32'h33, 32'h44, 1, 32'h44};
        tbl[6]  = '{1, 0, 0, 0, 0, 0, 0, 32'h1000_0007, 32'h33, 32'h44, 32'hAA, 32'hBB, 0, 2, 1, 32'h1000_0005, 0, 32'h33, 32'h44, 0, 32'h44};
        tbl[7]  = '{0, 0, 1, 0, 0, 0, 0, 32'h1000_0007, 32'h55, 32'h66, 32'hAA, 32'hBB, 1, 1, 1, 32'h1000_0007, 1, 32'hAA, 32'h66, 0, 32'h44};
        tbl[8]  = '{0, 0, 0, 0, 0, 0, 0, 32'h1000_0008, 32'h55, 32'h66, 32'hAA, 32'hBB, 1, 1, 1, 32'h1000_0008, 1, 32'h55, 32'h66, 1, 32'h66};
        tbl[9]  = '{0, 1, 0, 0, 0, 0, 0, 32'h1000_0009, 32'h55, 32'h66, 32'hAA, 32'hBB, 1, 3, 0, 32'h1000_0008, 0, 32'h55, 32'h66, 0, 32'h66};
        tbl[10] = '{0, 0, 0, 0, 0, 0, 0, 32'h1000_000A, 32'h77, 32'h88, 32'hAA, 32'hBB, 1, 1, 1, 32'h1000_000A, 0, 32'h77, 32'h88, 0, 32'h66};
        tbl[11] = '{1, 1, 0, 0, 0, 0, 0, 32'h1000_000B, 32'h77, 32'h88, 32'hAA, 32'hBB, 1, 3, 0, 32'h1000_000A, 0, 32'h77, 32'h88, 0, 32'h88};
        tbl[12] = '{1, 0, 0, 0, 0, 0, 0, 32'h1000_000C, 32'h77, 32'h88, 32'hAA, 32'hBB, 0, 2, 0, 32'h1000_000A, 0, 32'h77, 32'h88, 0, 32'h88};
        tbl[13] = '{0, 0, 0, 0, 0, 0, 0, 32'h1000_000D, 32'h77, 32'h88, 32'hAA, 32'hBB, 1, 1, 1, 32'h1000_000D, 0, 32'h77, 32'h88, 0, 32'h88};

        idle_v = '{0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 32'h0};

        // Reset held for two edges
        reset = 1'b1;
        drive(idle_v);
        repeat (2) @(posedge clock);
        #1;
        check_all_zero("reset");

        // Release: one IDLE cycle with the PC held, then RUN
        @(negedge clock);
        reset = 1'b0;
        w_instr_32 = 32'h0000_0100;
        #1;
        chk("idle pc_en", 32'(w_pc_en), 32'd0);
        @(posedge clock);
        #1;
        chk("run state", 32'(dut.state_q), 32'd1);
        chk("run pc_en", 32'(w_pc_en), 32'd1);
        chk("run fd_valid", 32'(w_fd_valid), 32'd0);

        // Per-cycle vectors
        for (int i = 0; i < 14; i++) begin
            @(negedge clock);
            drive(tbl[i]);
            #1;
            chk($sformatf("v%0d pc_en", i), 32'(w_pc_en), 32'(tbl[i].e_pc_en));
            count_edge();
            @(posedge clock);
            #1;
            chk($sformatf("v%0d state", i),    32'(dut.state_q),  32'(tbl[i].e_state));
            chk($sformatf("v%0d fd_valid", i), 32'(w_fd_valid),   32'(tbl[i].e_fd_valid));
            chk($sformatf("v%0d fd_instr", i), w_fd_instr_32,     tbl[i].e_fd_instr);
            chk($sformatf("v%0d de_valid", i), 32'(w_de_valid),   32'(tbl[i].e_de_valid));
            chk($sformatf("v%0d ers", i),      w_ers_data_32,     tbl[i].e_ers);
            chk($sformatf("v%0d ert", i),      w_ert_data_32,     tbl[i].e_ert);
            chk($sformatf("v%0d em_valid", i), 32'(w_em_valid),   32'(tbl[i].e_em_valid));
            chk($sformatf("v%0d em_rt", i),    w_em_rt_data_32,   tbl[i].e_em_rt);
            chk($sformatf("v%0d stall_err", i),32'(w_stall_err),  32'd0);
        end

        // Watchdog: eight consecutive stalls trip the sticky error
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            w_stall = 1'b1;
            #1;
            chk($sformatf("wd%0d pc_en", k), 32'(w_pc_en), 32'd0);
            count_edge();
            @(posedge clock);
            #1;
            chk($sformatf("wd%0d stall_err", k), 32'(w_stall_err), (k == 8) ? 32'd1 : 32'd0);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            w_stall = 1'b0;
            count_edge();
            @(posedge clock);
            #1;
            chk($sformatf("wd sticky%0d", k), 32'(w_stall_err), 32'd1);
        end

`ifdef HAZARD_PERF_CNT_EN
        exp_sc = 32'(tb_stalls);
        exp_be = 32'(tb_bypasses);
`else
        exp_sc = 32'd0;
        exp_be = 32'd0;
`endif
        chk("perf stall_cycles",  w_stall_cycles_32,  exp_sc);
        chk("perf bypass_events", w_bypass_events_32, exp_be);

        // Reset wins over a simultaneous stall and flush
        @(negedge clock);
        reset = 1'b1;
        drive(tbl[11]);
        w_drs_data_32 = 32'h99;
        @(posedge clock);
        #1;
        reset = 1'b0;
        drive(idle_v);
        #1;
        check_all_zero("reset2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
